datapath_scoreboard: RTL

- Synthesizable result checker that sits on the output end of the adder datapath.
- Captures each operand pair (op_a, op_b) as it is issued and queues the expected sum.
- Compares each returned datapath result against the queued expectation and keeps pass/fail statistics and sticky error flags.
- Lets on-chip or long-running sims self-check without a behavioural bench.

---
 rtl/datapath_pkg.sv | 20 ++
 rtl/scoreboard_fifo.sv | 50 +++++
 rtl/datapath_scoreboard.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// rtl/datapath_pkg.sv - shared types, widths and expected-value helper for the datapath scoreboard
package datapath_pkg;

    localparam int SB_DATA_W = 32;
    localparam int SB_CNT_W  = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sb_state_t;

    // Adder model: carry out is discarded, result wraps modulo 2^SB_DATA_W.
    function automatic logic [SB_DATA_W-1:0] sb_expected(input logic [SB_DATA_W-1:0] a,
                                                          input logic [SB_DATA_W-1:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/scoreboard_fifo.sv
// rtl/scoreboard_fifo.sv - expected-value FIFO with async reset and synchronous clear
module scoreboard_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout,
    output logic          full,
    output logic          empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    // A push into a full FIFO is accepted only when a pop frees the head slot on the same edge.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign dout  = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/datapath_scoreboard.sv
// rtl/datapath_scoreboard.sv - adder result checker with pass/fail stats; optional DATAPATH_SB_TIMEOUT_EN drain timeout
module datapath_scoreboard
    import datapath_pkg::*;
#(
    parameter int DATA_W      = SB_DATA_W,
    parameter int DEPTH       = 8,
`ifdef DATAPATH_SB_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 64,
`endif
    parameter int CNT_W       = SB_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic              op_valid,
    input  logic [DATA_W-1:0] op_a,
    input  logic [DATA_W-1:0] op_b,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  pass_count,
    output logic [CNT_W-1:0]  fail_count,
    output logic              error,
    output logic              overflow,
    output logic              underflow,
    output logic [DATA_W-1:0] first_exp,
    output logic [DATA_W-1:0] first_got
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    sb_state_t         state;
    sb_state_t         state_next;
    logic [DATA_W-1:0] exp_sum;
    logic [DATA_W-1:0] head;
    logic              full;
    logic              empty;
    logic              push_req;
    logic              pop_req;
    logic              hit;
    logic              miss;
    logic              ovf_evt;
    logic              udf_evt;
    logic              timeout_evt;
    logic              fifo_clear;
    logic              mismatch_seen;

    assign exp_sum  = sb_expected(op_a, op_b);
    assign push_req = (state == RUN) && op_valid;
    assign pop_req  = ((state == RUN) || (state == DRAIN)) && res_valid;
    assign hit      = pop_req && !empty && (head == res_data);
    assign miss     = pop_req && !empty && (head != res_data);
    assign udf_evt  = pop_req && empty;
    assign ovf_evt  = push_req && full && !(pop_req && !empty);

    // Timeout discards whatever is still queued so DONE always leaves an empty FIFO.
    assign fifo_clear = start || timeout_evt;

    scoreboard_fifo #(
        .DW    (DATA_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (fifo_clear),
        .push  (push_req),
        .pop   (pop_req),
        .din   (exp_sum),
        .dout  (head),
        .full  (full),
        .empty (empty)
    );

`ifdef DATAPATH_SB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    logic [TW-1:0] idle_cnt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idle_cnt <= '0;
        end else if (start || (state != DRAIN) || res_valid) begin
            idle_cnt <= '0;
        end else begin
            idle_cnt <= idle_cnt + 1'b1;
        end
    end

    assign timeout_evt = (state == DRAIN) && !start && !res_valid && !empty &&
                         (idle_cnt == TW'(TIMEOUT_CYC - 1));
`else
    assign timeout_evt = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (start) state_next = RUN;
                     else if (stop) state_next = DRAIN;
            DRAIN:   if (start) state_next = RUN;
                     else if (empty || timeout_evt) state_next = DONE;
            DONE:    if (start) state_next = RUN;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state == RUN) || (state == DRAIN);
        done = (state == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pass_count    <= '0;
            fail_count    <= '0;
            error         <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            first_exp     <= '0;
            first_got     <= '0;
            mismatch_seen <= 1'b0;
        end else if (start) begin
            pass_count    <= '0;
            fail_count    <= '0;
            error         <= 1'b0;
            overflow      <= 1'b0;
            underflow     <= 1'b0;
            first_exp     <= '0;
            first_got     <= '0;
            mismatch_seen <= 1'b0;
        end else begin
            if (hit && (pass_count != CNT_MAX))  pass_count <= pass_count + 1'b1;
            if (miss && (fail_count != CNT_MAX)) fail_count <= fail_count + 1'b1;
            if (miss && !mismatch_seen) begin
                first_exp     <= head;
                first_got     <= res_data;
                mismatch_seen <= 1'b1;
            end
            if (ovf_evt) overflow  <= 1'b1;
            if (udf_evt) underflow <= 1'b1;
            if (miss || ovf_evt || udf_evt || timeout_evt) error <= 1'b1;
        end
    end

endmodule
